// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds characters from NUM_REQ
// requesters, one at a time, into a single uart_tx transmitter.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   req_valid    per-requester character pending (held until acked)
//   req_data     requester i at [i*DATA_BITS +: DATA_BITS]
//   req_ack      one-hot, one-cycle pulse when a character is captured
//   tx_start     start request to uart_tx
//   tx_data      captured character presented to uart_tx
//   tx_busy      uart_tx busy
//   tx_done      uart_tx completion pulse
//   grant_id     index of the requester owning the transmitter
//   active       high whenever the arbiter is not idle
//   timeout_err  one-cycle pulse when a transmission is abandoned
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic                           tx_start,
  output logic [DATA_BITS-1:0]           tx_data,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           active,
  output logic                           timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW:0]   NR_W    = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ-1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES-1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic [2:0]             retry_q, retry_d;
  logic [NUM_REQ-1:0]     req_ack_q, req_ack_d;
  logic                   tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
  logic [IW-1:0]          grant_id_q, grant_id_d;
  logic                   active_q, active_d;
  logic                   timeout_err_q, timeout_err_d;

  logic                   found;
  logic [IW-1:0]          win;
  logic [IW:0]            sum;
  logic [DATA_BITS-1:0]   win_data;
  logic                   timed_out;

  // Search from rr_ptr upward, wrapping; the first pending requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (sum >= NR_W) sum = sum - NR_W;
      if (!found && req_valid[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IW'(i)) win_data = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign timed_out = (to_cnt_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    to_cnt_d      = to_cnt_q;
    retry_d       = retry_q;
    req_ack_d     = '0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    timeout_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ack_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          tx_data_d  = win_data;
          grant_id_d = win;
          rr_ptr_d   = (win == LAST_ID) ? '0 : win + IW'(1);
          to_cnt_d   = '0;
          retry_d    = '0;
          // registered, so tx_start is high during the ISSUE cycle
          tx_start_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (tx_done) begin
          state_d = IDLE;
        end else if (timed_out) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
          retry_d  = '0;
          state_d  = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_done) begin
          state_d = IDLE;
        end else if (timed_out) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
          if (tx_busy) begin
            state_d = WAIT_DONE;
          end else if (retry_q == 3'd7) begin
            // uart_tx dropped the start (cts low); ask again
            tx_start_d = 1'b1;
            retry_d    = '0;
          end else begin
            retry_d = retry_q + 3'd1;
          end
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_d = IDLE;
        end else if (timed_out) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      to_cnt_q      <= '0;
      retry_q       <= '0;
      req_ack_q     <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      active_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      to_cnt_q      <= to_cnt_d;
      retry_q       <= retry_d;
      req_ack_q     <= req_ack_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      active_q      <= active_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign active      = active_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed bench for uart_tx_arbiter
// with a round-robin reference model and a simple uart_tx responder.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DB = 8;
  localparam int TO = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR*DB-1:0] req_data;
  logic [NR-1:0] req_ack;
  logic          tx_start;
  logic [DB-1:0] tx_data;
  logic          tx_busy;
  logic          tx_done;
  logic [1:0]    grant_id;
  logic          active;
  logic          timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .DATA_BITS(DB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ack(req_ack),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .grant_id(grant_id),
    .active(active),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int m_ptr = 0;
  bit hold_all = 0;
  int ack_cnt = 0;
  int start_cnt = 0;
  int terr_cnt = 0;
  int done_cnt = 0;
  int grants[$];
  int start_cyc[$];
  int terr_cyc[$];
  int u_phase = 0;
  int u_cnt = 0;
  int u_ignore = 0;
  int busy_dly = 3;
  int done_dly = 100;
  bit u_never = 0;

  function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++)
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  task automatic step();
    logic [NR-1:0] pv;
    logic [NR*DB-1:0] pd;
    logic pa;
    logic [DB-1:0] ptd;
    logic [1:0] pg;
    logic [NR-1:0] pack;
    pv = req_valid; pd = req_data; pa = active;
    ptd = tx_data; pg = grant_id; pack = req_ack;
    @(posedge clk); #1; cyc++;
    checks++;
    if ($countones(req_ack) > 1 || (req_ack != 0 && pack != 0)) begin
      fails++;
      $display("FAIL ack_pulse: got %b prev %b required one-hot single cycle",
               req_ack, pack);
    end
    if (req_ack != '0) begin
      int w;
      logic [NR-1:0] ea;
      w = rr_pick(pv, m_ptr);
      ea = '0;
      if (w >= 0) ea[w] = 1'b1;
      checks++;
      if (pa !== 1'b0 || active !== 1'b1) begin
        fails++;
        $display("FAIL ack_window: active %b->%b required 0->1", pa, active);
      end
      checks++;
      if (req_ack !== ea) begin
        fails++;
        $display("FAIL ack_winner: got %b required %b", req_ack, ea);
      end
      if (w >= 0) begin
        checks++;
        if (grant_id !== 2'(w) || tx_data !== pd[w*DB +: DB]) begin
          fails++;
          $display("FAIL capture: got id %0d data %h required id %0d data %h",
                   grant_id, tx_data, w, pd[w*DB +: DB]);
        end
        m_ptr = (w + 1) % NR;
        grants.push_back(w);
        if (!hold_all) req_valid[w] = 1'b0;
      end
      ack_cnt++;
    end else begin
      checks++;
      if (tx_data !== ptd || grant_id !== pg) begin
        fails++;
        $display("FAIL hold: got %h/%0d required %h/%0d",
                 tx_data, grant_id, ptd, pg);
      end
    end
    if (tx_start) begin start_cnt++; start_cyc.push_back(cyc); end
    if (timeout_err) begin terr_cnt++; terr_cyc.push_back(cyc); end
    tx_done = 1'b0;
    case (u_phase)
      0: if (tx_start && !u_never) begin
        if (u_ignore > 0) u_ignore--;
        else begin u_phase = 1; u_cnt = busy_dly; end
      end
      1: begin
        u_cnt--;
        if (u_cnt == 0) begin tx_busy = 1'b1; u_phase = 2; u_cnt = done_dly; end
      end
      default: begin
        u_cnt--;
        if (u_cnt == 0) begin tx_busy = 1'b0; tx_done = 1'b1; u_phase = 0; end
      end
    endcase
    if (tx_done) done_cnt++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ack !== '0 || tx_start !== 1'b0 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulses: got ack %b start %b terr %b required 0",
               req_ack, tx_start, timeout_err);
    end
    checks++;
    if (tx_data !== '0 || grant_id !== '0 || active !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs: got data %h id %0d active %b required 0",
               tx_data, grant_id, active);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (active !== 1'b0 || tx_start !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_req: got active %b start %b required 0",
               active, tx_start);
    end
  endtask

  task automatic test_fairness();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    int a0 = ack_cnt;
    int n = 0;
    grants.delete();
    hold_all = 1;
    busy_dly = 1;
    done_dly = 3;
    req_data = 32'h43424140;
    req_valid = 4'b1111;
    while (ack_cnt - a0 < 6 && n < 400) begin step(); n++; end
    req_valid = '0;
    hold_all = 0;
    n = 0;
    while (active && n < 100) begin step(); n++; end
    checks++;
    if (grants.size() != 6) begin
      fails++;
      $display("FAIL fair_count: got %0d grants required 6", grants.size());
    end
    for (int i = 0; i < 6 && i < grants.size(); i++) begin
      checks++;
      if (grants[i] != exp_seq[i]) begin
        fails++;
        $display("FAIL fair_seq[%0d]: got %0d required %0d",
                 i, grants[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_single();
    int a0 = ack_cnt;
    int s0 = start_cnt;
    int d0 = done_cnt;
    int n = 0;
    busy_dly = 3;
    done_dly = 100;
    req_data = $urandom();
    req_data[15:8] = 8'hA5;
    req_valid = 4'b0010;
    while (done_cnt == d0 && n < 400) begin step(); n++; end
    checks++;
    if (done_cnt == d0) begin
      fails++;
      $display("FAIL single_wait: no tx_done within %0d cycles", n);
    end
    step();
    checks++;
    if (active !== 1'b0) begin
      fails++;
      $display("FAIL single_active: got %b after tx_done required 0", active);
    end
    checks++;
    if (ack_cnt - a0 != 1 || start_cnt - s0 != 1) begin
      fails++;
      $display("FAIL single_pulses: got acks %0d starts %0d required 1 1",
               ack_cnt - a0, start_cnt - s0);
    end
    checks++;
    if (tx_data !== 8'hA5 || grant_id !== 2'd1) begin
      fails++;
      $display("FAIL single_data: got %h/%0d required a5/1", tx_data, grant_id);
    end
  endtask

  task automatic test_dropped_start();
    int a0 = ack_cnt;
    int t0 = start_cyc.size();
    int d0 = done_cnt;
    int n = 0;
    busy_dly = 3;
    done_dly = 20;
    u_ignore = 1;
    req_valid = 4'b0100;
    while (done_cnt == d0 && n < 400) begin step(); n++; end
    step();
    checks++;
    if (start_cyc.size() - t0 != 2) begin
      fails++;
      $display("FAIL retry_count: got %0d starts required 2",
               start_cyc.size() - t0);
    end else begin
      checks++;
      if (start_cyc[t0+1] - start_cyc[t0] != 9) begin
        fails++;
        $display("FAIL retry_gap: got %0d cycles required 9",
                 start_cyc[t0+1] - start_cyc[t0]);
      end
    end
    checks++;
    if (ack_cnt - a0 != 1 || done_cnt - d0 != 1 || active !== 1'b0) begin
      fails++;
      $display("FAIL retry_xfer: got acks %0d dones %0d active %b required 1 1 0",
               ack_cnt - a0, done_cnt - d0, active);
    end
  endtask

  task automatic test_timeout();
    int t0 = start_cyc.size();
    int tr0 = terr_cnt;
    int a0 = ack_cnt;
    int n = 0;
    u_never = 1;
    req_valid = 4'b1001;
    while (terr_cnt == tr0 && n < TO + 40) begin step(); n++; end
    checks++;
    if (terr_cnt == tr0 || start_cyc.size() <= t0) begin
      fails++;
      $display("FAIL timeout_wait: no timeout_err within %0d cycles", n);
    end else begin
      checks++;
      if (terr_cyc[$] - start_cyc[t0] != TO) begin
        fails++;
        $display("FAIL timeout_time: got %0d cycles required %0d",
                 terr_cyc[$] - start_cyc[t0], TO);
      end
    end
    checks++;
    if (active !== 1'b0 || grant_id !== 2'd3) begin
      fails++;
      $display("FAIL timeout_idle: got active %b id %0d required 0 3",
               active, grant_id);
    end
    step();
    checks++;
    if (timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse: got %b required 0", timeout_err);
    end
    n = 0;
    while (ack_cnt - a0 < 2 && n < 10) begin step(); n++; end
    checks++;
    if (ack_cnt - a0 != 2 || grant_id !== 2'd0) begin
      fails++;
      $display("FAIL timeout_next: got acks %0d id %0d required 2 0",
               ack_cnt - a0, grant_id);
    end
    n = 0;
    while (terr_cnt - tr0 < 2 && n < TO + 40) begin step(); n++; end
    u_never = 0;
    step();
  endtask

  task automatic test_collision();
    int t0 = start_cyc.size();
    int tr0 = terr_cnt;
    int d0 = done_cnt;
    int n = 0;
    busy_dly = 3;
    done_dly = TO - 4;
    req_valid = 4'b0010;
    while (done_cnt == d0 && n < TO + 40) begin step(); n++; end
    checks++;
    if (start_cyc.size() <= t0 || cyc - start_cyc[t0] != TO - 1) begin
      fails++;
      $display("FAIL collide_setup: tx_done at cycle %0d, start queue %0d",
               cyc, start_cyc.size() - t0);
    end
    step();
    checks++;
    if (active !== 1'b0 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL collide: got active %b terr %b required 0 0",
               active, timeout_err);
    end
    repeat (3) step();
    checks++;
    if (terr_cnt != tr0) begin
      fails++;
      $display("FAIL collide_terr: got %0d pulses required 0", terr_cnt - tr0);
    end
  endtask

  task automatic test_reset_mid();
    int tr0;
    int a0;
    int n = 0;
    busy_dly = 3;
    done_dly = 100;
    req_valid = 4'b0010;
    while (tx_busy !== 1'b1 && n < 20) begin step(); n++; end
    repeat (5) step();
    req_data = $urandom();
    req_valid = 4'b0101;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ack !== '0 || tx_start !== 1'b0 || timeout_err !== 1'b0 ||
        tx_data !== '0 || grant_id !== '0 || active !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got ack %b st %b te %b d %h id %0d act %b required 0",
               req_ack, tx_start, timeout_err, tx_data, grant_id, active);
    end
    u_phase = 0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    m_ptr = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tr0 = terr_cnt;
    a0 = ack_cnt;
    done_dly = 5;
    n = 0;
    while (ack_cnt == a0 && n < 10) begin step(); n++; end
    checks++;
    if (req_ack !== 4'b0001 || grant_id !== 2'd0) begin
      fails++;
      $display("FAIL reset_regrant: got %b/%0d required 0001/0",
               req_ack, grant_id);
    end
    n = 0;
    while ((req_valid != '0 || active) && n < 200) begin step(); n++; end
    checks++;
    if (terr_cnt != tr0 || req_valid != '0) begin
      fails++;
      $display("FAIL reset_after: got terr %0d pending %b required 0 0000",
               terr_cnt - tr0, req_valid);
    end
  endtask

  task automatic test_random();
    int a0 = ack_cnt;
    int s0 = start_cnt;
    int tr0 = terr_cnt;
    int n = 0;
    while (ack_cnt - a0 < 30 && n < 3000) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i]) begin
          req_data[i*DB +: DB] = 8'($urandom());
          if ($urandom_range(0, 5) == 0) req_valid[i] = 1'b1;
        end
      end
      if (u_phase == 0) begin
        busy_dly = $urandom_range(1, 6);
        done_dly = $urandom_range(1, 20);
      end
      step();
      n++;
    end
    checks++;
    if (ack_cnt - a0 < 30) begin
      fails++;
      $display("FAIL rand_progress: got %0d acks required 30", ack_cnt - a0);
    end
    n = 0;
    while ((req_valid != '0 || active) && n < 2000) begin step(); n++; end
    checks++;
    if (start_cnt - s0 != ack_cnt - a0 || terr_cnt != tr0) begin
      fails++;
      $display("FAIL rand_balance: got starts %0d acks %0d terr %0d required equal, 0",
               start_cnt - s0, ack_cnt - a0, terr_cnt - tr0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    test_reset();
    test_fairness();
    test_single();
    test_dropped_start();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
